// File: rtl/sha_wnd_mem_resp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sha_wnd_mem_resp_pkg                                         |
// | Description : Shared constants for the SHA-256 memory responder: K table,  |
// |               IV words, H bank indices and load FSM state encodings.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sha_wnd_mem_resp_pkg;

  localparam logic [1:0] c_bank_iv  = 2'd0;
  localparam logic [1:0] c_bank_mid = 2'd1;
  localparam logic [1:0] c_bank_fin = 2'd2;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_load = 2'd1;
  localparam logic [1:0] c_st_full = 2'd2;

  localparam logic [31:0] c_iv_tab [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] c_k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_const(input logic [5:0] idx);
    return c_k_tab[idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha_wnd_mem_resp_k_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sha_k_rom                                                    |
// | Description : Combinational 64x32 SHA-256 K lookup; 0 beyond round 63.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sha_k_rom
  import sha_wnd_mem_resp_pkg::*;
(
  input  logic [7:0]  i_addr,
  output logic [31:0] o_data
);

  logic w_in_range;

  assign w_in_range = (i_addr[7:6] == 2'b00);
  assign o_data     = w_in_range ? k_const(i_addr[5:0]) : 32'h0;

endmodule
`default_nettype wire

// File: rtl/sha_wnd_mem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sha_wnd_mem_resp                                             |
// | Description : Memory-side responder for a SHA-256 core: K ROM, 3-bank H    |
// |               store, 32-word message buffer with stream load, digest port. |
// |               Option SHA_RESP_BSWAP_EN byte-reverses DIG_RD.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sha_wnd_mem_resp
  import sha_wnd_mem_resp_pkg::*;
#(
  parameter int MSG_WORDS = 32,
  parameter int H_BANKS   = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  MKA,
  input  logic [7:0]  HA,
  input  logic [1:0]  H_BANK,
  input  logic        H_WE,
  input  logic [31:0] HD_WR,
  input  logic        BLK_SEL,
  output logic [31:0] MD,
  output logic [31:0] KD,
  output logic [31:0] HD_RD,
  input  logic        M_CLR,
  input  logic        M_VALID,
  input  logic [31:0] M_DATA,
  output logic        M_READY,
  output logic        M_FULL,
  output logic [5:0]  M_CNT,
  input  logic [2:0]  DIG_RA,
  output logic [31:0] DIG_RD,
  output logic        ERR
);

  localparam logic [5:0] c_cnt_last = 6'(MSG_WORDS - 1);

  logic [31:0] r_h [H_BANKS][8];
  logic [31:0] r_m [MSG_WORDS];
  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic        r_err;
  logic [31:0] r_dig;

  logic        w_h_ok;
  logic        w_ready;
  logic        w_accept;
  logic [31:0] w_hd_rd;
  logic [31:0] w_dig_raw;
  logic [31:0] w_dig_next;

  sha_k_rom u_k_rom (
    .i_addr (MKA),
    .o_data (KD)
  );

  // Core-facing reads are combinational so the core samples data in its address cycle.
  assign w_h_ok = (HA < 8'd8) && (H_BANK < 2'(H_BANKS));

  always_comb begin
    w_hd_rd = 32'h0;
    if (w_h_ok) begin
      w_hd_rd = r_h[H_BANK][HA[2:0]];
    end
  end

  assign HD_RD = w_hd_rd;
  assign MD    = r_m[{BLK_SEL, MKA[3:0]}];

  assign w_dig_raw = r_h[c_bank_fin][DIG_RA];
`ifdef SHA_RESP_BSWAP_EN
  assign w_dig_next = {w_dig_raw[7:0], w_dig_raw[15:8], w_dig_raw[23:16], w_dig_raw[31:24]};
`else
  assign w_dig_next = w_dig_raw;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int b = 0; b < H_BANKS; b++) begin
        for (int w = 0; w < 8; w++) begin
          r_h[b][w] <= (b == int'(c_bank_iv)) ? c_iv_tab[w] : 32'h0;
        end
      end
      r_err <= 1'b0;
      r_dig <= 32'h0;
    end else begin
      if (H_WE) begin
        if (w_h_ok) begin
          r_h[H_BANK][HA[2:0]] <= HD_WR;
        end else begin
          r_err <= 1'b1;
        end
      end
      r_dig <= w_dig_next;
    end
  end

  assign w_ready  = (r_state != c_st_full) && !M_CLR;
  assign w_accept = M_VALID && w_ready;

  // M_CLR rewinds the write pointer but leaves buffered words in place.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= c_st_idle;
      r_cnt   <= 6'd0;
      for (int i = 0; i < MSG_WORDS; i++) begin
        r_m[i] <= 32'h0;
      end
    end else if (M_CLR) begin
      r_state <= c_st_idle;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        c_st_idle, c_st_load: begin
          if (w_accept) begin
            r_m[r_cnt[4:0]] <= M_DATA;
            r_cnt           <= r_cnt + 6'd1;
            r_state         <= (r_cnt == c_cnt_last) ? c_st_full : c_st_load;
          end
        end
        c_st_full: r_state <= c_st_full;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

  assign M_READY = w_ready;
  assign M_FULL  = (r_state == c_st_full);
  assign M_CNT   = r_cnt;
  assign ERR     = r_err;
  assign DIG_RD  = r_dig;

endmodule
`default_nettype wire

// File: tb/tb_sha_wnd_mem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sha_wnd_mem_resp                                          |
// | Description : Self-checking bench for sha_wnd_mem_resp (directed + random).|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sha_wnd_mem_resp;

  logic        CLK = 1'b0;
  logic        RST, H_WE, BLK_SEL, M_CLR, M_VALID;
  logic [7:0]  MKA, HA;
  logic [1:0]  H_BANK;
  logic [31:0] HD_WR, M_DATA;
  logic [2:0]  DIG_RA;
  logic [31:0] MD, KD, HD_RD, DIG_RD;
  logic        M_READY, M_FULL, ERR;
  logic [5:0]  M_CNT;

  int tests = 0;
  int fails = 0;

  logic [31:0] k_tab [64];
  logic [31:0] iv_tab [8];
  logic [31:0] hvec [8];
  logic [31:0] genesis [32];
  logic [31:0] model_h [3][8];
  logic [31:0] model_m [32];
  int          model_cnt;
  logic        model_err;

  sha_wnd_mem_resp dut (
    .CLK(CLK), .RST(RST), .MKA(MKA), .HA(HA), .H_BANK(H_BANK), .H_WE(H_WE),
    .HD_WR(HD_WR), .BLK_SEL(BLK_SEL), .MD(MD), .KD(KD), .HD_RD(HD_RD),
    .M_CLR(M_CLR), .M_VALID(M_VALID), .M_DATA(M_DATA), .M_READY(M_READY),
    .M_FULL(M_FULL), .M_CNT(M_CNT), .DIG_RA(DIG_RA), .DIG_RD(DIG_RD), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] dig_view(input logic [31:0] w);
`ifdef SHA_RESP_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] k_expect(input logic [7:0] a);
    return (a < 8'd64) ? k_tab[a[5:0]] : 32'h0;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 3; b++)
      for (int w = 0; w < 8; w++)
        model_h[b][w] = (b == 0) ? iv_tab[w] : 32'h0;
    for (int i = 0; i < 32; i++) model_m[i] = 32'h0;
    model_cnt = 0;
    model_err = 1'b0;
  endtask

  task automatic check_banks(input string tag);
    for (int b = 0; b < 3; b++)
      for (int w = 0; w < 8; w++) begin
        H_BANK = 2'(b); HA = 8'(w); #1;
        check(tag, HD_RD, model_h[b][w]);
      end
  endtask

  task automatic hwrite(input int bank, input int ha, input logic [31:0] d);
    H_BANK = 2'(bank); HA = 8'(ha); HD_WR = d; H_WE = 1'b1;
    step();
    H_WE = 1'b0;
    if (ha < 8 && bank < 3) model_h[bank][ha] = d;
    else model_err = 1'b1;
  endtask

  initial begin
    logic [31:0] dig_exp;
    logic        rd_exp;

    k_tab = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    iv_tab = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    hvec = '{32'hbc909a33, 32'h6358bff0, 32'h90ccac7d, 32'h1e9be84d,
             32'h8e89a3c4, 32'h7b3d7dc1, 32'h2d6c7bab, 32'h4719f91b};
    genesis = '{32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa,
                32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c, 32'h80000000, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000280};

    RST = 1'b1; H_WE = 1'b0; BLK_SEL = 1'b0; M_CLR = 1'b0; M_VALID = 1'b0;
    MKA = 8'd0; HA = 8'd0; H_BANK = 2'd0; HD_WR = 32'h0; M_DATA = 32'h0; DIG_RA = 3'd0;
    step(); step();
    RST = 1'b0;
    model_reset();
    #1;
    check("rst_m_cnt", 32'(M_CNT), 32'd0);
    check("rst_m_full", 32'(M_FULL), 32'd0);
    check("rst_m_ready", 32'(M_READY), 32'd1);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_dig_rd", DIG_RD, 32'h0);

    MKA = 8'd0;  #1; check("kd_0", KD, 32'h428a2f98);
    MKA = 8'd63; #1; check("kd_63", KD, 32'hc67178f2);
    MKA = 8'd64; #1; check("kd_64", KD, 32'h00000000);
    check_banks("rst_banks");

    for (int i = 0; i < 8; i++) hwrite(1, i, hvec[i]);
    check_banks("bank1_write");

    hwrite(2, 0, 32'hbc909a33);
    DIG_RA = 3'd0;
    step();
    check("dig_rd_word0", DIG_RD, dig_view(32'hbc909a33));

    // Genesis header stream with M_VALID held high.
    M_VALID = 1'b1;
    for (int i = 0; i < 32; i++) begin
      M_DATA = genesis[i]; #1;
      check("load_ready", 32'(M_READY), 32'd1);
      check("load_cnt", 32'(M_CNT), 32'(i));
      step();
      model_m[i] = genesis[i];
    end
    model_cnt = 32;
    check("full_flag", 32'(M_FULL), 32'd1);
    check("full_ready", 32'(M_READY), 32'd0);
    M_DATA = 32'hdeadbeef;
    step();
    check("full_no_wrap", 32'(M_CNT), 32'd32);
    M_VALID = 1'b0;
    BLK_SEL = 1'b0; MKA = 8'd9;  #1; check("md_b0_9", MD, 32'h3ba3edfd);
    BLK_SEL = 1'b1; MKA = 8'd4;  #1; check("md_b1_4", MD, 32'h80000000);
    BLK_SEL = 1'b0; MKA = 8'd25; #1; check("md_alias_25", MD, 32'h3ba3edfd);
    M_CLR = 1'b1; #1;
    check("clr_ready_low", 32'(M_READY), 32'd0);
    step();
    M_CLR = 1'b0; model_cnt = 0; #1;
    check("clr_cnt", 32'(M_CNT), 32'd0);
    check("clr_ready", 32'(M_READY), 32'd1);
    check("clr_full", 32'(M_FULL), 32'd0);
    check("clr_keeps_data", MD, 32'h3ba3edfd);

    M_CLR = 1'b1; M_VALID = 1'b1; M_DATA = 32'h12345678;
    step();
    M_CLR = 1'b0; M_VALID = 1'b0;
    check("clr_beats_valid", 32'(M_CNT), 32'd0);

    hwrite(1, 8, 32'hffffffff);
    check("err_ha8", 32'(ERR), 32'd1);
    check_banks("err_no_write");
    hwrite(3, 0, 32'h55555555);
    check("err_sticky", 32'(ERR), 32'd1);

    // Randomized mix of H traffic, stream loads and digest reads.
    for (int cyc = 0; cyc < 400; cyc++) begin
      int bank, ha, widx;
      bank    = int'($urandom_range(0, 3));
      ha      = int'($urandom_range(0, 9));
      H_BANK  = 2'(bank);
      HA      = 8'(ha);
      H_WE    = ($urandom_range(0, 2) == 0);
      HD_WR   = $urandom;
      MKA     = 8'($urandom_range(0, 255));
      BLK_SEL = 1'($urandom_range(0, 1));
      DIG_RA  = 3'($urandom_range(0, 7));
      M_CLR   = ($urandom_range(0, 24) == 0);
      M_VALID = ($urandom_range(0, 3) != 0);
      M_DATA  = $urandom;
      #1;
      check("rnd_kd", KD, k_expect(MKA));
      check("rnd_hd_rd", HD_RD, (ha < 8 && bank < 3) ? model_h[bank][ha] : 32'h0);
      widx = {BLK_SEL, MKA[3:0]};
      check("rnd_md", MD, model_m[widx]);
      rd_exp = (model_cnt < 32) && !M_CLR;
      check("rnd_ready", 32'(M_READY), 32'(rd_exp));
      dig_exp = model_h[2][DIG_RA];
      step();
      if (H_WE) begin
        if (ha < 8 && bank < 3) model_h[bank][ha] = HD_WR;
        else model_err = 1'b1;
      end
      if (M_CLR) model_cnt = 0;
      else if (M_VALID && rd_exp) begin
        model_m[model_cnt] = M_DATA;
        model_cnt++;
      end
      check("rnd_cnt", 32'(M_CNT), 32'(model_cnt));
      check("rnd_full", 32'(M_FULL), 32'(model_cnt == 32));
      check("rnd_err", 32'(ERR), 32'(model_err));
      check("rnd_dig", DIG_RD, dig_view(dig_exp));
    end
    H_WE = 1'b0; M_CLR = 1'b0; M_VALID = 1'b0;
    check_banks("rnd_banks_final");

    // Reset in the middle of a load discards everything.
    M_CLR = 1'b1; step(); M_CLR = 1'b0;
    M_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      M_DATA = $urandom | 32'h1;
      step();
    end
    M_VALID = 1'b0;
    check("mid_load_cnt", 32'(M_CNT), 32'd5);
    RST = 1'b1; step(); RST = 1'b0;
    model_reset();
    #1;
    check("rst2_cnt", 32'(M_CNT), 32'd0);
    check("rst2_err", 32'(ERR), 32'd0);
    check("rst2_dig", DIG_RD, 32'h0);
    check("rst2_ready", 32'(M_READY), 32'd1);
    for (int i = 0; i < 32; i++) begin
      BLK_SEL = 1'(i / 16); MKA = 8'(i % 16); #1;
      check("rst2_md", MD, 32'h0);
    end
    check_banks("rst2_banks");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
